// File: rtl/downsample_pkg.sv
// Shared definitions for the down-sampling engine and the UART loader that
// shares its SRAM.
package downsample_pkg;

    // State encoding kept as plain constants for legacy tool compatibility
    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_RD_ADDR  = 3'd1;
    localparam logic [ST_W-1:0] ST_RD_DATA  = 3'd2;
    localparam logic [ST_W-1:0] ST_WR_SETUP = 3'd3;
    localparam logic [ST_W-1:0] ST_WR_PULSE = 3'd4;

    localparam logic MODE_AVG = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // SRAM pin values whenever the engine does not own the bus
    localparam logic CE_IDLE     = 1'b1;
    localparam logic OE_IDLE     = 1'b1;
    localparam logic WE_IDLE     = 1'b1;
    localparam logic UB_IDLE     = 1'b1;
    localparam logic LB_IDLE     = 1'b1;
    localparam logic BUS_OE_IDLE = 1'b0;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/downsample_engine_tick_gen.sv
// Free-running divider producing the SRAM step enable; tick marks the last
// clk of each CLK_DIV period and is held high when CLK_DIV is 1.
module tick_gen #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (cnt == CNT_MAX) cnt <= '0;
        else                     cnt <= cnt + CNT_W'(1);
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/downsample_engine.sv
// Hardwired image down-sampler: box-average or decimate an IMG_W x IMG_H
// 8-bit image held in SRAM and write the reduced image back to SRAM.
module downsample_engine
    import downsample_pkg::*;
#(
    parameter int unsigned IMG_W   = 256,
    parameter int unsigned IMG_H   = 256,
    parameter int unsigned FACTOR  = 2,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned CLK_DIV = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_address,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic              bus_oe,
    output logic              chip_en,
    output logic              output_enable,
    output logic              data_enable,
    output logic              UB,
    output logic              LB
);
    localparam int unsigned LOG2F = $clog2(FACTOR);
    localparam int unsigned OW    = IMG_W / FACTOR;
    localparam int unsigned OH    = IMG_H / FACTOR;
    localparam int unsigned ACC_W = 8 + 2 * LOG2F;
    localparam int unsigned KW    = (LOG2F > 0) ? LOG2F : 1;
    localparam int unsigned XW    = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned YW    = (OH > 1) ? $clog2(OH) : 1;
    localparam logic [KW-1:0] KMAX = KW'(FACTOR - 1);
    localparam logic [XW-1:0] XMAX = XW'(OW - 1);
    localparam logic [YW-1:0] YMAX = YW'(OH - 1);

    if ((IMG_W % FACTOR) != 0 || (IMG_H % FACTOR) != 0 || !is_pow2(FACTOR)
        || FACTOR < 2 || FACTOR > 8) begin : g_cfg_check
        $error("downsample_engine: IMG_W/IMG_H must be multiples of a power-of-two FACTOR in 2..8");
    end

    logic              tick;
    logic [ST_W-1:0]   state, state_nxt;
    logic              pending, pending_nxt;
    logic              mode_q, mode_nxt;
    logic [ADDR_W-1:0] src_q, src_nxt, dst_q, dst_nxt;
    logic [KW-1:0]     kx, kx_nxt, ky, ky_nxt;
    logic [XW-1:0]     ox, ox_nxt;
    logic [YW-1:0]     oy, oy_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic              accept, kernel_last, out_last;
    logic              busy_nxt, done_nxt;
    logic [ADDR_W-1:0] rd_addr, wr_addr, addr_nxt;
    logic [7:0]        result;
    logic [15:0]       wdata_nxt;
    logic              bus_oe_nxt, ce_nxt, oe_nxt, we_nxt, ub_nxt, lb_nxt;
    logic              unused_rdata_hi;

    assign unused_rdata_hi = ^sram_rdata[15:8];

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Next-state, counter/accumulator update and SRAM pin decode
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        mode_nxt    = mode_q;
        src_nxt     = src_q;
        dst_nxt     = dst_q;
        kx_nxt      = kx;
        ky_nxt      = ky;
        ox_nxt      = ox;
        oy_nxt      = oy;
        acc_nxt     = acc;
        done_nxt    = 1'b0;
        accept      = start && !busy && !abort;
        kernel_last = (mode_q == MODE_DEC) || (kx == KMAX && ky == KMAX);
        out_last    = (ox == XMAX) && (oy == YMAX);

        if (accept) begin
            pending_nxt = 1'b1;
            mode_nxt    = mode;
            src_nxt     = src_base;
            dst_nxt     = dst_base;
        end

        if (abort) begin
            state_nxt   = ST_IDLE;
            pending_nxt = 1'b0;
            kx_nxt      = '0;
            ky_nxt      = '0;
            ox_nxt      = '0;
            oy_nxt      = '0;
            acc_nxt     = '0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (pending_nxt) begin
                        state_nxt   = ST_RD_ADDR;
                        pending_nxt = 1'b0;
                        kx_nxt      = '0;
                        ky_nxt      = '0;
                        ox_nxt      = '0;
                        oy_nxt      = '0;
                        acc_nxt     = '0;
                    end
                end
                ST_RD_ADDR: state_nxt = ST_RD_DATA;
                ST_RD_DATA: begin
                    acc_nxt = (mode_q == MODE_DEC) ? ACC_W'(sram_rdata[7:0])
                                                   : acc + ACC_W'(sram_rdata[7:0]);
                    if (kernel_last) begin
                        state_nxt = ST_WR_SETUP;
                        kx_nxt    = '0;
                        ky_nxt    = '0;
                    end else begin
                        state_nxt = ST_RD_ADDR;
                        if (kx == KMAX) begin
                            kx_nxt = '0;
                            ky_nxt = ky + KW'(1);
                        end else begin
                            kx_nxt = kx + KW'(1);
                        end
                    end
                end
                ST_WR_SETUP: state_nxt = ST_WR_PULSE;
                ST_WR_PULSE: begin
                    acc_nxt = '0;
                    if (out_last) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                        ox_nxt    = '0;
                        oy_nxt    = '0;
                    end else begin
                        state_nxt = ST_RD_ADDR;
                        if (ox == XMAX) begin
                            ox_nxt = '0;
                            oy_nxt = oy + YW'(1);
                        end else begin
                            ox_nxt = ox + XW'(1);
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        busy_nxt = (state_nxt != ST_IDLE) || pending_nxt;

        // Addresses wrap silently at ADDR_W bits
        rd_addr = src_nxt
                + ((ADDR_W'(oy_nxt) << LOG2F) + ADDR_W'(ky_nxt)) * ADDR_W'(IMG_W)
                + (ADDR_W'(ox_nxt) << LOG2F) + ADDR_W'(kx_nxt);
        wr_addr = dst_nxt + ADDR_W'(oy_nxt) * ADDR_W'(OW) + ADDR_W'(ox_nxt);
        result  = (mode_q == MODE_DEC) ? acc_nxt[7:0] : 8'(acc_nxt >> (2 * LOG2F));

        addr_nxt   = '0;
        wdata_nxt  = '0;
        bus_oe_nxt = BUS_OE_IDLE;
        ce_nxt     = CE_IDLE;
        oe_nxt     = OE_IDLE;
        we_nxt     = WE_IDLE;
        ub_nxt     = UB_IDLE;
        lb_nxt     = LB_IDLE;
        case (state_nxt)
            ST_RD_ADDR, ST_RD_DATA: begin
                addr_nxt = rd_addr;
                ce_nxt   = 1'b0;
                oe_nxt   = 1'b0;
                lb_nxt   = 1'b0;
            end
            ST_WR_SETUP, ST_WR_PULSE: begin
                addr_nxt   = wr_addr;
                wdata_nxt  = {8'h00, result};
                bus_oe_nxt = 1'b1;
                ce_nxt     = 1'b0;
                ub_nxt     = 1'b0;
                lb_nxt     = 1'b0;
                we_nxt     = (state_nxt != ST_WR_PULSE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pending       <= 1'b0;
            mode_q        <= MODE_AVG;
            src_q         <= '0;
            dst_q         <= '0;
            kx            <= '0;
            ky            <= '0;
            ox            <= '0;
            oy            <= '0;
            acc           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sram_address  <= '0;
            sram_wdata    <= '0;
            bus_oe        <= BUS_OE_IDLE;
            chip_en       <= CE_IDLE;
            output_enable <= OE_IDLE;
            data_enable   <= WE_IDLE;
            UB            <= UB_IDLE;
            LB            <= LB_IDLE;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            mode_q        <= mode_nxt;
            src_q         <= src_nxt;
            dst_q         <= dst_nxt;
            kx            <= kx_nxt;
            ky            <= ky_nxt;
            ox            <= ox_nxt;
            oy            <= oy_nxt;
            acc           <= acc_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            sram_address  <= addr_nxt;
            sram_wdata    <= wdata_nxt;
            bus_oe        <= bus_oe_nxt;
            chip_en       <= ce_nxt;
            output_enable <= oe_nxt;
            data_enable   <= we_nxt;
            UB            <= ub_nxt;
            LB            <= lb_nxt;
        end
    end

endmodule
